// File: rtl/rotador.sv
// -----------------------------------------------------------------------------
// rotador
//
// Word-rotation stage with an output FIFO. Each accepted beat has its
// unqualified words zeroed, then is rotated word-wise by a running counter
// that advances once per accepted beat. The rotated beat and its rotated
// valid mask are queued in a small FIFO for the downstream consumer.
// An error from upstream flushes the FIFO, clears the rotation counter and
// holds the block in an error state until the error flag drops.
//
// Ports
//   clk          : clock, all state on rising edge
//   reset        : asynchronous active-low reset
//   data_in      : word-packed input bus, word i = bits [i*WORD_SIZE +: WORD_SIZE]
//   control_in   : per-word valid mask, bit i qualifies word i
//   error_in     : upstream error flag
//   ready_in     : downstream ready
//   data_out     : rotated bus at FIFO head (0 when FIFO empty)
//   control_out  : rotated mask at FIFO head (0 when FIFO empty)
//   valid_out    : FIFO head valid
//   error_out    : high while in the error state
//   overflow_out : sticky, a beat was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module rotador #(
    parameter int BUS_SIZE   = 60,
    parameter int WORD_SIZE  = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [BUS_SIZE-1:0]           data_in,
    input  logic [BUS_SIZE/WORD_SIZE-1:0] control_in,
    input  logic                          error_in,
    input  logic                          ready_in,
    output logic [BUS_SIZE-1:0]           data_out,
    output logic [BUS_SIZE/WORD_SIZE-1:0] control_out,
    output logic                          valid_out,
    output logic                          error_out,
    output logic                          overflow_out
);

    localparam int WORD_NUM = BUS_SIZE / WORD_SIZE;
    localparam int RW       = (WORD_NUM > 1) ? $clog2(WORD_NUM) : 1;
    localparam int PW       = $clog2(FIFO_DEPTH);
    localparam int CW       = PW + 1;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_ERR = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [RW-1:0]         rot_q, rot_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;

    logic [BUS_SIZE-1:0]   data_mem [FIFO_DEPTH];
    logic [WORD_NUM-1:0]   ctrl_mem [FIFO_DEPTH];

    logic [BUS_SIZE-1:0]   data_masked;
    logic [BUS_SIZE-1:0]   data_rot;
    logic [WORD_NUM-1:0]   ctrl_rot;
    logic                  accept;
    logic                  full;
    logic                  push;
    logic                  pop;

    // Zero every word whose mask bit is clear before it is rotated.
    always_comb begin
        data_masked = '0;
        for (int i = 0; i < WORD_NUM; i++) begin
            if (control_in[i]) begin
                data_masked[i*WORD_SIZE +: WORD_SIZE] = data_in[i*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    // Output word j takes input word (j + rot) mod WORD_NUM: shifting a doubled
    // copy of the bus right by rot words and keeping the low half does exactly
    // that without a per-word mux tree description.
    assign data_rot = BUS_SIZE'({data_masked, data_masked} >> (int'(rot_q) * WORD_SIZE));
    assign ctrl_rot = WORD_NUM'({control_in, control_in} >> rot_q);

    // The edge that leaves the error state may also accept a beat, so accept
    // only looks at error_in and not at the current state.
    assign accept = !error_in && (control_in != '0);
    assign full   = (count_q == CW'(FIFO_DEPTH));

    // NOTE: every signal written in this block gets a default first so that no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        rot_d      = rot_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        push       = 1'b0;
        pop        = 1'b0;

        if (error_in) begin
            // Entering (or staying in) the error state flushes everything.
            state_d  = ST_ERR;
            rot_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            state_d = ST_RUN;
            pop     = valid_out && ready_in;
            if (accept) begin
                rot_d = (rot_q == RW'(WORD_NUM - 1)) ? '0 : rot_q + RW'(1);
                // A full FIFO still takes the beat if the head leaves this edge.
                if (!full || pop) begin
                    push = 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
            end
            wr_ptr_d = wr_ptr_q + PW'(push);
            rd_ptr_d = rd_ptr_q + PW'(pop);
            count_d  = count_q + CW'(push) - CW'(pop);
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the values from before the edge, independent of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            rot_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rot_q      <= rot_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; its contents are only
    // visible through the valid-gated outputs, and the pointers/count that
    // define validity are reset.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= data_rot;
            ctrl_mem[wr_ptr_q] <= ctrl_rot;
        end
    end

    assign valid_out    = (state_q == ST_RUN) && (count_q != '0);
    assign data_out     = valid_out ? data_mem[rd_ptr_q] : '0;
    assign control_out  = valid_out ? ctrl_mem[rd_ptr_q] : '0;
    assign error_out    = (state_q == ST_ERR);
    assign overflow_out = overflow_q;

endmodule

// File: doc/rotador.md
ROTADOR -- requirements
Module: rotador

Interface
REQ-001 Parameter BUS_SIZE, 60, total data bus width in bits.
REQ-002 Parameter WORD_SIZE, 6, word width in bits; WORD_NUM = BUS_SIZE/WORD_SIZE (10) is derived, not overridable.
REQ-003 Parameter FIFO_DEPTH, 4, output FIFO entries (power of two, >=2).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (low = asserted).
REQ-006 data_in  input  BUS_SIZE  word-packed bus from the parity mux stage; word i = bits [i*WORD_SIZE+WORD_SIZE-1 : i*WORD_SIZE].
REQ-007 control_in  input  WORD_NUM  per-word valid mask from the mux stage; bit i qualifies word i.
REQ-008 error_in  input  1  error flag from the mux stage.
REQ-009 ready_in  input  1  downstream ready.
REQ-010 data_out  output  BUS_SIZE  rotated bus at FIFO head.
REQ-011 control_out  output  WORD_NUM  rotated mask at FIFO head.
REQ-012 valid_out  output  1  FIFO head valid.
REQ-013 error_out  output  1  high while in ERR state.
REQ-014 overflow_out  output  1  sticky flag, a word was dropped on full FIFO.

Function
REQ-015 FSM states RUN and ERR only; RUN->ERR when error_in=1 at an edge; ERR->RUN at the first edge with error_in=0.
REQ-016 Accept condition at an edge: state RUN, error_in=0, control_in != 0; no backpressure to upstream.
REQ-017 Before rotation each word i with control_in[i]=0 is forced to zero.
REQ-018 Rotation: output word j = masked input word (j + rot_cnt) mod WORD_NUM; control mask rotated identically.
REQ-019 rot_cnt is a counter 0..WORD_NUM-1, +1 after each accept, wraps WORD_NUM-1 -> 0; value used for a beat is the pre-increment value.
REQ-020 Accepted beat is written to the FIFO on the accept edge; pop occurs on an edge with valid_out=1 and ready_in=1.
REQ-021 Latency: beat accepted at edge N into an empty FIFO appears on data_out/control_out with valid_out=1 after edge N (one cycle).
REQ-022 valid_out = FIFO not empty; when empty data_out and control_out read 0.
REQ-023 Full and accept with simultaneous pop: write succeeds, no overflow.
REQ-024 Full and accept without pop: beat dropped, rot_cnt still increments, overflow_out set to 1 and held until reset.
REQ-025 Empty and pop request: no effect.
REQ-026 Entering ERR (edge with error_in=1): FIFO flushed, rot_cnt cleared to 0, incoming beat discarded, error_out=1 after that edge.
REQ-027 While in ERR: no writes, no pops, valid_out=0, error_out=1.
REQ-028 Returning to RUN: error_out=0 after the transition edge; a beat meeting REQ-016 on that same edge is accepted with rot_cnt=0.
REQ-029 FIFO ordering is strict first-in first-out; data held stable at head while ready_in=0.

Reset
REQ-030 reset low forces immediately, independent of clk: state RUN, rot_cnt 0, FIFO empty, data_out 0, control_out 0, valid_out 0, error_out 0, overflow_out 0.
REQ-031 Reset asserted mid-operation discards all FIFO content; first edge after reset release behaves as from power-up.

Verification
REQ-032 Words i=0..9 valued i+1, control_in=0x3FF, ready_in=1, two beats -> beat 1 out words 1..10 unchanged; beat 2 out word0=2 ... word8=10, word9=1.
REQ-033 Eleven consecutive accepts -> rot_cnt wraps; 11th beat output identical to 1st (rotation 0).
REQ-034 control_in=0x001 with word0=0x3F, rot_cnt=3 -> data_out word7=0x3F, all other words 0, control_out=0x080.
REQ-035 ready_in=0, five accepts with FIFO_DEPTH=4 -> four beats held in order, overflow_out=1 after 5th edge; then ready_in=1 drains beats 1..4 in order.
REQ-036 Two beats queued, error_in=1 one cycle -> valid_out=0, error_out=1 for one cycle, next accepted beat uses rotation 0.
REQ-037 reset pulsed low between clock edges with FIFO non-empty -> all outputs 0 immediately, no stale beat after release.
